// File: rtl/cpu_parameters.sv
// Shared CPU-wide parameters and the fetch controller state encoding.
package cpu_parameters;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state;

  // Clear the byte-offset bits so an address always points at a whole word.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer between the memory port and the PC generator.
// Flush discards everything; a push and a pop in the same cycle both happen.
module fetch_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wrPtr;
  logic         r_rdPtr;
  logic [1:0]   r_count;
  logic         w_doPush;
  logic         w_doPop;

  assign full     = (r_count == 2'd2);
  assign empty    = (r_count == 2'd0);
  assign rdata    = r_mem[r_rdPtr];
  assign w_doPush = push & (~full | pop);
  assign w_doPop  = pop & ~empty;

  // Storage, pointers and occupancy; flush resets the pointers so the head reads entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= wdata;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request at a time,
// responses buffered in a two-entry FIFO, redirects drop in-flight work.
module fetch_ctrl
  import cpu_parameters::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] start_address,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            instruction_v,
  input  logic            ok_i,
  input  logic            jal_instr,
  input  logic [XLEN-1:0] next_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_correction,
  output logic            busy
);

  fetch_state      r_state;
  logic [XLEN-1:0] r_fetchAddr;
  logic [XLEN-1:0] r_memAddr;
  logic            r_stale;
  logic            r_reqRedir;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_redirect;
  logic            w_goHold;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fetchNext;

  assign instruction_v = ~w_empty;
  assign w_pop         = ok_i & instruction_v;
  assign w_redirect    = flush | (w_pop & jal_instr);
  assign w_target      = alignWord(flush ? pc_correction : next_pc);
  assign w_push        = (r_state == WAIT) & mem_rvalid & ~r_stale & ~w_redirect;
  assign w_goHold      = ~w_empty & ~w_pop;

  assign mem_req  = (r_state == REQ);
  assign mem_addr = r_memAddr;
  assign busy     = (r_state == REQ) | (r_state == WAIT);

  fetch_buf #(.W(XLEN)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redirect),
    .wdata (mem_rdata),
    .rdata (instruction),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next fetch address: redirect target wins, otherwise advance only on a clean grant.
  always_comb begin
    w_fetchNext = r_fetchAddr;
    case (r_state)
      IDLE:    w_fetchNext = w_redirect ? w_target : alignWord(start_address);
      REQ: begin
        if (w_redirect) begin
          w_fetchNext = w_target;
        end else if (mem_gnt && !r_reqRedir) begin
          w_fetchNext = r_fetchAddr + XLEN'(4);
        end
      end
      default: w_fetchNext = w_redirect ? w_target : r_fetchAddr;
    endcase
  end

  // Fetch FSM; the presented address is frozen while a request waits for its grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_fetchAddr <= '0;
      r_memAddr   <= '0;
      r_stale     <= 1'b0;
      r_reqRedir  <= 1'b0;
    end else begin
      r_fetchAddr <= w_fetchNext;
      if (r_state != REQ) begin
        r_memAddr <= w_fetchNext;
      end
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (mem_gnt) begin
            r_state    <= WAIT;
            r_stale    <= r_reqRedir | w_redirect;
            r_reqRedir <= 1'b0;
          end else if (w_redirect) begin
            r_reqRedir <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_stale <= 1'b0;
            r_state <= (w_push && w_goHold) ? HOLD : REQ;
          end else if (w_redirect) begin
            r_stale <= 1'b1;
          end
        end
        HOLD: begin
          if (w_redirect || w_pop) begin
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic w_unusedFull;
  assign w_unusedFull = w_full;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run
// checked against an instruction-stream model of what the consumer must see.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] start_address = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instruction;
  logic        instruction_v;
  logic        ok_i = 1'b0;
  logic        jal_instr = 1'b0;
  logic [31:0] next_pc = '0;
  logic        flush = 1'b0;
  logic [31:0] pc_correction = '0;
  logic        busy;

  int nVectors = 0;
  int nMiscompares = 0;

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_address (start_address),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .instruction_v (instruction_v),
    .ok_i          (ok_i),
    .jal_instr     (jal_instr),
    .next_pc       (next_pc),
    .flush         (flush),
    .pc_correction (pc_correction),
    .busy          (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Memory contents: each word identifies the address it came from.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs across a rising edge, return at the next falling edge.
  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic ok, input logic jal, input logic [31:0] npc,
                               input logic fl, input logic [31:0] pcc);
    mem_gnt       = gnt;
    mem_rvalid    = rvalid;
    mem_rdata     = rdata;
    ok_i          = ok;
    jal_instr     = jal;
    next_pc       = npc;
    flush         = fl;
    pc_correction = pcc;
    @(negedge clk);
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_instr_v"}, 32'(instruction_v), 32'd0);
    checkOutput({tag, "_instr"}, instruction, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic doReset(input logic [31:0] addr);
    rst_n         = 1'b0;
    start_address = addr;
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b0;
    ok_i          = 1'b0;
    jal_instr     = 1'b0;
    flush         = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        rGnt, rRv, rOk, rJal, rFl, rPop;
  logic [31:0] rNpc, rPcc, rRd;
  logic        pending;
  logic [31:0] pendAddr;
  logic [31:0] expPc;
  logic        redirLast;
  int          gap;
  int          maxGap;

  initial begin
    $display("[TB] fetch_ctrl bench starting");
    @(negedge clk);

    // Basic streaming from 0x1000 with immediate grant and response.
    doReset(32'h0000_1000);
    idleStep();
    checkOutput("first_req", 32'(mem_req), 32'd1);
    checkOutput("first_addr", mem_addr, 32'h0000_1000);
    checkOutput("first_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wait_no_req", 32'(mem_req), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, memWord(32'h1000), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("instr0_v", 32'(instruction_v), 32'd1);
    checkOutput("instr0", instruction, memWord(32'h1000));
    checkOutput("addr1", mem_addr, 32'h0000_1004);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("pop0_empty", 32'(instruction_v), 32'd0);
    applyStimulus(1'b0, 1'b1, memWord(32'h1004), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("instr1", instruction, memWord(32'h1004));
    checkOutput("addr2", mem_addr, 32'h0000_1008);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'h1008), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("instr2", instruction, memWord(32'h1008));
    checkOutput("addr3", mem_addr, 32'h0000_100C);

    // Consumer stalls: buffer fills, fetch parks in HOLD, one pop restarts it.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'h100C), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("hold_no_req", 32'(mem_req), 32'd0);
    checkOutput("hold_not_busy", 32'(busy), 32'd0);
    checkOutput("hold_head", instruction, memWord(32'h1008));
    idleStep();
    checkOutput("hold_stays", 32'(mem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("hold_exit_req", 32'(mem_req), 32'd1);
    checkOutput("hold_exit_addr", mem_addr, 32'h0000_1010);
    checkOutput("hold_exit_head", instruction, memWord(32'h100C));

    // Flush while waiting: the in-flight response is discarded.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
    checkOutput("flush_empties", 32'(instruction_v), 32'd0);
    checkOutput("flush_wait_no_req", 32'(mem_req), 32'd0);
    applyStimulus(1'b0, 1'b1, memWord(32'h1010), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("stale_dropped", 32'(instruction_v), 32'd0);
    checkOutput("flush_target_req", 32'(mem_req), 32'd1);
    checkOutput("flush_target_addr", mem_addr, 32'h0000_2000);

    // Flush and JAL together while a request waits for grant: flush target wins.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'h2000), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("instr_2000", instruction, memWord(32'h2000));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_4000);
    checkOutput("redir_req_addr_stable", mem_addr, 32'h0000_2004);
    checkOutput("redir_req_empty", 32'(instruction_v), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'h2004), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("flush_wins_addr", mem_addr, 32'h0000_4000);
    checkOutput("stale_grant_dropped", 32'(instruction_v), 32'd0);

    // Redirect coincident with grant to an unaligned top-of-memory target, then wrap.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, memWord(32'h4000), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("top_addr", mem_addr, 32'hFFFF_FFFC);
    checkOutput("top_dropped", 32'(instruction_v), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_addr", mem_addr, 32'h0000_0000);
    checkOutput("wrap_instr", instruction, memWord(32'hFFFF_FFFC));

    // Asynchronous reset in the middle of a transaction; late response is ignored.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async");
    @(negedge clk);
    start_address = 32'h0000_5000;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("restart_req", 32'(mem_req), 32'd1);
    checkOutput("restart_addr", mem_addr, 32'h0000_5000);
    checkOutput("late_rvalid_ignored", 32'(instruction_v), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'h5000), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("restart_instr", instruction, memWord(32'h5000));

    // Randomized run: the consumer must see a gap-free address stream that
    // restarts at each redirect target.
    doReset({$urandom} & 32'hFFFF_FFFC);
    expPc = start_address;
    idleStep();
    pending   = 1'b0;
    pendAddr  = '0;
    redirLast = 1'b0;
    gap       = 0;
    maxGap    = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pending) checkOutput("one_outstanding", 32'(mem_req), 32'd0);
      if (mem_req) checkOutput("addr_aligned", 32'(mem_addr[1:0]), 32'd0);
      if (redirLast) checkOutput("redirect_empties", 32'(instruction_v), 32'd0);

      rGnt = mem_req && ($urandom_range(2) != 0);
      rRv  = pending && ($urandom_range(1) != 0);
      rRd  = rRv ? memWord(pendAddr) : $urandom;
      rOk  = ($urandom_range(3) != 0);
      rJal = ($urandom_range(7) == 0);
      rFl  = ($urandom_range(15) == 0);
      rNpc = $urandom;
      rPcc = $urandom;
      rPop = rOk && instruction_v;

      if (rPop) begin
        checkOutput("stream", instruction, memWord(expPc));
        gap = 0;
      end else begin
        gap++;
        if (gap > maxGap) maxGap = gap;
      end
      if (rFl) expPc = rPcc & 32'hFFFF_FFFC;
      else if (rPop && rJal) expPc = rNpc & 32'hFFFF_FFFC;
      else if (rPop) expPc = expPc + 32'd4;
      redirLast = rFl | (rPop & rJal);

      if (rRv) pending = 1'b0;
      if (rGnt) begin
        pending  = 1'b1;
        pendAddr = mem_addr;
      end
      applyStimulus(rGnt, rRv, rRd, rOk, rJal, rNpc, rFl, rPcc);
    end
    checkOutput("liveness", 32'(maxGap < 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset; SHALL force the reset state immediately on assertion, independent of clk.
REQ-003 start_address  input  xlen  first fetch address after reset.
REQ-004 mem_req  output  1  fetch request to the instruction memory port.
REQ-005 mem_addr  output  xlen  fetch address; SHALL be word-aligned.
REQ-006 mem_gnt  input  1  memory accepted the request this cycle.
REQ-007 mem_rvalid  input  1  response data valid.
REQ-008 mem_rdata  input  32  fetched instruction word.
REQ-009 instruction  output  xlen  instruction word at the buffer head, sent to the PC generator.
REQ-010 instruction_v  output  1  buffer head valid.
REQ-011 ok_i  input  1  PC generator consumed the head this cycle.
REQ-012 jal_instr  input  1  the consumed instruction is a JAL.
REQ-013 next_pc  input  xlen  PC-generator target, used when jal_instr is set.
REQ-014 flush  input  1  backend redirect.
REQ-015 pc_correction  input  xlen  redirect target.
REQ-016 busy  output  1  a request is outstanding (state REQ or WAIT).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT and HOLD.
REQ-018 IDLE SHALL load fetch_addr=start_address and go to REQ on the next cycle.
REQ-019 REQ SHALL drive mem_req=1 and mem_addr=fetch_addr; both SHALL stay stable until mem_gnt.
REQ-020 REQ with mem_gnt SHALL go to WAIT and update fetch_addr<=fetch_addr+4, modulo 2^xlen with silent wrap.
REQ-021 At most one request SHALL be outstanding; mem_req=0 in WAIT, HOLD and IDLE.
REQ-022 WAIT with mem_rvalid and the stale flag clear SHALL push mem_rdata into a 2-entry FIFO.
REQ-023 After that push, WAIT SHALL go to REQ if the FIFO is not full after the push, otherwise to HOLD.
REQ-024 HOLD SHALL go to REQ in the cycle after a pop leaves the FIFO non-full.
REQ-025 instruction and instruction_v SHALL reflect the FIFO head combinationally.
REQ-026 A pop SHALL occur when ok_i=1 and instruction_v=1; ok_i with an empty FIFO SHALL be ignored.
REQ-027 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-028 A redirect SHALL occur on flush=1, or on a pop with jal_instr=1; the target SHALL be pc_correction, or next_pc for a JAL.
REQ-029 When flush and JAL coincide, flush SHALL win.
REQ-030 A redirect SHALL empty the FIFO, load fetch_addr<=target with bits[1:0] forced to 0, and let no further entries issue before the target.
REQ-031 Redirect in WAIT before mem_rvalid SHALL set the stale flag.
REQ-032 A stale response SHALL be dropped without a push, SHALL clear the stale flag and SHALL go to REQ.
REQ-033 Redirect in WAIT coincident with mem_rvalid SHALL drop that response and go to REQ.
REQ-034 Redirect in REQ before mem_gnt SHALL keep mem_addr stable.
REQ-035 A request redirected in REQ SHALL be marked stale when granted, and fetch_addr SHALL keep the target (no +4).
REQ-036 Redirect in HOLD SHALL go to REQ on the next cycle.
REQ-037 Redirect in the same cycle as a grant SHALL mark that request stale and keep fetch_addr at the target.
REQ-038 Minimum latency from request to instruction_v SHALL be gnt-cycle + rvalid-cycle + 1 register stage.

Reset
REQ-039 rst_n low SHALL set state=IDLE, FIFO empty, stale=0 and fetch_addr=0.
REQ-040 Outputs SHALL be 0 during reset: mem_req, mem_addr, instruction_v, instruction and busy.
REQ-041 Reset mid-transaction SHALL abandon the request; a later mem_rvalid SHALL be ignored unless the block is in WAIT.

Structure
REQ-042 xlen and the fetch_state enum SHALL live in cpu_parameters.
REQ-043 The FIFO SHALL be the existing parameterised fifo module, or a 2-entry sub-module fetch_buf with push, pop, flush, full and empty.

Verification
REQ-044 Reset release with start_address=0x1000, gnt and rvalid on the following cycle, ok_i=1 -> mem_addr sequence 0x1000, 0x1004, 0x1008; instructions delivered in order.
REQ-045 ok_i held 0 -> two instructions buffered, then state HOLD with mem_req=0; one ok_i pulse -> a new request at the next address.
REQ-046 flush with pc_correction=0x2000 while in WAIT -> the following response is dropped, instruction_v stays 0, the next mem_addr is 0x2000.
REQ-047 Pop with jal_instr=1 and next_pc=0x3000 while flush=1 and pc_correction=0x4000 -> the next mem_addr is 0x4000.
REQ-048 fetch_addr=0xFFFFFFFC with a grant -> the next address is 0x0.
REQ-049 rst_n asserted in WAIT, then rvalid after release -> no push; mem_req restarts at start_address.
